// File: rtl/cpu_common.sv
// rtl/cpu_common.sv - shared CPU constants and types
package cpu_common;

  localparam int unsigned INST_MEM_WORDS = 8192;
  localparam int unsigned INST_MEM_BYTES = 16384;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_LO = 3'd1,
    LOAD_HI = 3'd2,
    FLUSH   = 3'd3,
    DONE    = 3'd4
  } inst_mem_load_state_t;

endpackage

// File: rtl/inst_mem_ram.sv
// rtl/inst_mem_ram.sv - simple dual-port block RAM, read-first registered output
module inst_mem_ram #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_async,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Output register samples the array before this edge's write lands: read-first.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/inst_mem.sv
// rtl/inst_mem.sv - instruction memory with fetch read port and byte-stream program loader
module inst_mem
  import cpu_common::*;
#(
  parameter int ADDR_WIDTH = 13,
  parameter int LEN_WIDTH  = 15
) (
  input  logic                  clk,
  input  logic                  rst_async,
  input  logic [ADDR_WIDTH-1:0] mem_inst_addr,
  output logic [15:0]           mem_instr,
  input  logic                  load_start,
  input  logic [LEN_WIDTH-1:0]  load_len,
  input  logic [7:0]            load_byte,
  input  logic                  load_valid,
  output logic                  load_ready,
  output logic                  load_done,
  output logic                  cpu_hold
);

  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(INST_MEM_BYTES);

  inst_mem_load_state_t state;
  logic [LEN_WIDTH-1:0] len;
  logic [LEN_WIDTH-1:0] cnt;
  logic [LEN_WIDTH-1:0] cnt_inc;
  logic [LEN_WIDTH-1:0] start_len;
  logic [7:0]           lo;
  logic                 wr_en;
  logic [15:0]          wr_data;
  logic                 last_byte;

  assign cnt_inc   = cnt + LEN_WIDTH'(1);
  assign last_byte = (cnt_inc == len);
  assign start_len = (load_len > MAX_LEN) ? MAX_LEN : load_len;

  assign load_ready = (state == LOAD_LO) || (state == LOAD_HI);
  assign load_done  = (state == DONE);
  assign cpu_hold   = (state != IDLE);

  // FLUSH pads the odd trailing byte with a zero high half.
  assign wr_en   = ((state == LOAD_HI) && load_valid) || (state == FLUSH);
  assign wr_data = (state == FLUSH) ? {8'h00, lo} : {load_byte, lo};

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state <= IDLE;
      len   <= '0;
      cnt   <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_start) begin
            len   <= start_len;
            cnt   <= '0;
            state <= (start_len == '0) ? DONE : LOAD_LO;
          end
        end
        LOAD_LO: begin
          if (load_valid) begin
            lo    <= load_byte;
            cnt   <= cnt_inc;
            state <= last_byte ? FLUSH : LOAD_HI;
          end
        end
        LOAD_HI: begin
          if (load_valid) begin
            cnt   <= cnt_inc;
            state <= last_byte ? DONE : LOAD_LO;
          end
        end
        FLUSH:   state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  inst_mem_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(16)
  ) u_ram (
    .clk      (clk),
    .rst_async(rst_async),
    .wr_en    (wr_en),
    .wr_addr  (cnt[ADDR_WIDTH:1]),
    .wr_data  (wr_data),
    .rd_addr  (mem_inst_addr),
    .rd_data  (mem_instr)
  );

endmodule

// File: tb/tb_inst_mem.sv
// tb/tb_inst_mem.sv - scoreboard bench for inst_mem with randomized reads and loads
module tb_inst_mem;

  localparam int AW = 13;
  localparam int LW = 15;

  logic          clk = 1'b0;
  logic          rst_async;
  logic [AW-1:0] mem_inst_addr;
  logic [15:0]   mem_instr;
  logic          load_start;
  logic [LW-1:0] load_len;
  logic [7:0]    load_byte;
  logic          load_valid;
  logic          load_ready;
  logic          load_done;
  logic          cpu_hold;

  always #5 clk = ~clk;

  inst_mem #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk          (clk),
    .rst_async    (rst_async),
    .mem_inst_addr(mem_inst_addr),
    .mem_instr    (mem_instr),
    .load_start   (load_start),
    .load_len     (load_len),
    .load_byte    (load_byte),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_done    (load_done),
    .cpu_hold     (cpu_hold)
  );

  int tests = 0;
  int fails = 0;

  bit [15:0] model [8192];
  bit        known [8192];
  bit [7:0]  ld_bytes [16384];

  typedef struct {
    int        due;
    int        addr;
    bit [15:0] exp;
  } rd_t;
  rd_t sb[$];
  rd_t e;

  int cyc = 0;
  int rd_mode = 0;
  int rd_base = 0;
  int rd_a;

  int done_cnt = 0, hold_cnt = 0, flush_cnt = 0, acc_cnt = 0, ready_cnt = 0;
  int last_acc_cyc = 0, done_cyc = 0;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one byte after an idle gap; returns just after the edge that accepted it.
  task automatic send_byte(input bit [7:0] b, input int gap);
    int n;
    if (gap > 0) begin
      load_valid = 1'b0;
      repeat (gap) tick();
    end
    load_byte  = b;
    load_valid = 1'b1;
    n = 0;
    while (!load_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check("ready_wait", 0, 1);
    tick();
  endtask

  task automatic run_load(input string nm, input int len, input int gap,
                          input int start_at, input int stop_rd_at);
    int d0, h0, f0, a0, r0, s, eff, odd, n;
    eff = (len > 16384) ? 16384 : len;
    odd = eff % 2;
    d0 = done_cnt; h0 = hold_cnt; f0 = flush_cnt; a0 = acc_cnt; r0 = ready_cnt;
    load_start = 1'b1;
    load_len   = LW'(len);
    s = cyc;
    tick();
    load_start = 1'b0;
    load_len   = LW'($urandom);
    for (int i = 0; i < eff; i++) begin
      if (i == start_at) begin
        load_start = 1'b1;
        load_len   = LW'(2);
      end
      send_byte(ld_bytes[i], (i == 0) ? 0 : gap);
      load_start = 1'b0;
      if (i == stop_rd_at) rd_mode = 0;
    end
    // Bytes offered after the last one must be dropped.
    load_byte  = 8'h5A;
    load_valid = 1'b1;
    repeat (2) tick();
    load_valid = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 200) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check({nm, "_done_pulses"}, done_cnt - d0, 1);
    check({nm, "_accepted"}, acc_cnt - a0, eff);
    check({nm, "_flush_cycles"}, flush_cnt - f0, odd);
    if (eff == 0) begin
      check({nm, "_ready_cycles"}, ready_cnt - r0, 0);
    end
    if (gap == 0) begin
      check({nm, "_hold_cycles"}, hold_cnt - h0, eff + odd + 1);
      check({nm, "_done_cycle"}, done_cyc - s, eff + odd + 1);
    end
    for (int i = 0; i < eff; i += 2) begin
      model[i/2] = (i + 1 < eff) ? {ld_bytes[i+1], ld_bytes[i]} : {8'h00, ld_bytes[i]};
      known[i/2] = 1'b1;
    end
  endtask

  task automatic reads(input int mode, input int base, input int n);
    rd_base = base;
    rd_mode = mode;
    repeat (n) @(posedge clk);
    #1;
    rd_mode = 0;
    repeat (3) tick();
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0, a0;
    rst_async     = 1'b1;
    load_start    = 1'b0;
    load_len      = '0;
    load_byte     = '0;
    load_valid    = 1'b0;
    mem_inst_addr = '0;

    fork
      forever begin
        @(posedge clk);
        cyc++;
      end
      // Read driver: each expected word is taken from the model when the address is issued.
      forever begin
        @(posedge clk);
        #2;
        if (rd_mode != 0) begin
          if (rd_mode == 1) begin
            rd_a = ($urandom_range(0, 3) == 0) ? 8191 - int'($urandom_range(0, 3))
                                               : int'($urandom_range(0, 15));
          end else begin
            rd_a = rd_base & 8191;
            if (rd_mode == 2) rd_base++;
          end
          mem_inst_addr = AW'(rd_a);
          if (known[rd_a]) sb.push_back('{due: cyc + 1, addr: rd_a, exp: model[rd_a]});
        end
      end
      forever begin
        @(negedge clk);
        while (sb.size() > 0 && sb[0].due <= cyc) begin
          e = sb.pop_front();
          if (e.due < cyc) check("rd_late", cyc, e.due);
          else check($sformatf("rd_word%0d", e.addr), mem_instr, e.exp);
        end
        if (!rst_async) begin
          if (load_done) begin
            done_cnt++;
            done_cyc = cyc;
          end
          if (cpu_hold) hold_cnt++;
          if (cpu_hold && !load_ready && !load_done) flush_cnt++;
          if (load_ready) ready_cnt++;
          if (load_valid && load_ready) begin
            acc_cnt++;
            last_acc_cyc = cyc;
          end
        end
      end
    join_none

    repeat (2) tick();
    check("rst_mem_instr", mem_instr, 16'h0000);
    check("rst_load_ready", load_ready, 0);
    check("rst_load_done", load_done, 0);
    check("rst_cpu_hold", cpu_hold, 0);
    rst_async = 1'b0;
    tick();

    ld_bytes[0] = 8'h11; ld_bytes[1] = 8'h22; ld_bytes[2] = 8'h33; ld_bytes[3] = 8'h44;
    run_load("even4", 4, 0, -1, -1);
    check("even4_last_acc", done_cyc - last_acc_cyc, 1);
    check("even4_word0", model[0], 16'h2211);
    reads(2, 0, 2);

    // Read word 0 throughout a load; the read at the write edge must see the old word.
    ld_bytes[0] = 8'h99; ld_bytes[1] = 8'h88;
    rd_base = 0;
    rd_mode = 3;
    run_load("rdfirst", 2, 0, -1, 1);
    reads(1, 0, 20);

    ld_bytes[0] = 8'hAA; ld_bytes[1] = 8'hBB; ld_bytes[2] = 8'hCC;
    run_load("odd3_gap", 3, 2, -1, -1);
    check("odd3_word1", model[1], 16'h00CC);
    reads(2, 0, 2);

    run_load("len0", 0, 0, -1, -1);
    reads(1, 0, 10);

    for (int i = 0; i < 6; i++) ld_bytes[i] = 8'($urandom);
    run_load("start_midload", 6, 0, 2, -1);
    for (int i = 0; i < 4; i++) ld_bytes[i] = 8'($urandom);
    run_load("start_lastbyte", 4, 0, 3, -1);
    reads(1, 0, 20);

    h0 = hold_cnt;
    a0 = acc_cnt;
    load_byte  = 8'hEE;
    load_valid = 1'b1;
    repeat (5) tick();
    load_valid = 1'b0;
    tick();
    check("idle_valid_hold", hold_cnt - h0, 0);
    check("idle_valid_acc", acc_cnt - a0, 0);
    reads(2, 0, 4);

    for (int i = 0; i < 6; i++) ld_bytes[i] = 8'($urandom);
    load_start = 1'b1;
    load_len   = LW'(6);
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 3; i++) send_byte(ld_bytes[i], 0);
    load_valid = 1'b0;
    rst_async  = 1'b1;
    #1;
    check("midrst_load_ready", load_ready, 0);
    check("midrst_cpu_hold", cpu_hold, 0);
    check("midrst_load_done", load_done, 0);
    check("midrst_mem_instr", mem_instr, 16'h0000);
    repeat (2) tick();
    rst_async = 1'b0;
    model[0] = {ld_bytes[1], ld_bytes[0]};
    tick();
    reads(2, 0, 2);
    for (int i = 0; i < 6; i++) ld_bytes[i] = 8'($urandom);
    run_load("after_rst", 6, 0, -1, -1);
    reads(1, 0, 20);

    for (int i = 0; i < 16384; i++) ld_bytes[i] = 8'($urandom);
    run_load("clamp20000", 20000, 0, -1, -1);
    check("clamp_known8191", known[8191], 1);
    reads(2, 8190, 2);
    reads(1, 0, 30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/inst_mem.md
Name: inst_mem

Overview:
Instruction memory responder: the far end of the CPU fetch interface. It serves 16-bit words to the fetch unit with fixed one-cycle read latency. It also contains a byte-stream loader that packs incoming program bytes little-endian into words and writes them starting at word 0. While a load is in progress it asserts cpu_hold so the core stalls.

Parameters:
ADDR_WIDTH, 13, word address width (8192 x 16-bit words = 16 KiB)
LEN_WIDTH, 15, width of load_len in bytes (max meaningful value 16384)

Ports:
clk  input  1  clock
rst_async  input  1  reset, asynchronous, active-high
mem_inst_addr  input  ADDR_WIDTH  word address from the fetch unit
mem_instr  output  16  registered read data for the address presented on the previous edge
load_start  input  1  single-cycle pulse: begin a program load
load_len  input  LEN_WIDTH  byte count, sampled on load_start
load_byte  input  8  program byte
load_valid  input  1  load_byte is valid
load_ready  output  1  loader accepts a byte this cycle
load_done  output  1  one-cycle pulse when a load completes
cpu_hold  output  1  core must stall; high whenever the FSM is not in IDLE

Behaviour:
- Reset, clock: rst_async is asynchronous, active-high; all state is clocked on posedge clk.
- Reset values: FSM=IDLE, mem_instr=16'h0000, load_ready=0, load_done=0, cpu_hold=0, byte counter=0, low-byte latch=0.
- RAM contents are not reset.
- Read port:
  - mem_instr <= ram[mem_inst_addr] on every edge outside reset, in all FSM states.
  - Latency is exactly 1 cycle.
  - Same-address read during write returns the old word (read-first).
- FSM states: IDLE, LOAD_LO, LOAD_HI, FLUSH, DONE.
- IDLE:
  - On load_start: latch len = min(load_len, 16384) and clear cnt.
  - If len==0, go to DONE; otherwise go to LOAD_LO.
- LOAD_LO:
  - load_ready=1.
  - On load_valid: latch lo=load_byte, cnt+=1.
  - If cnt+1==len, go to FLUSH; otherwise go to LOAD_HI.
- LOAD_HI:
  - load_ready=1.
  - On load_valid: write ram[cnt[13:1]] = {load_byte, lo}, cnt+=1.
  - If cnt+1==len, go to DONE; otherwise go to LOAD_LO.
- FLUSH (odd length only):
  - load_ready=0.
  - Write ram[cnt[13:1]] = {8'h00, lo}, then go to DONE.
- DONE: load_done=1 for exactly one cycle, then go to IDLE.
- Byte acceptance: a byte is consumed only when load_valid && load_ready. load_ready is a combinational function of state only, never of load_valid.
- load_start outside IDLE is ignored. load_start and the final byte in the same cycle: the start is ignored.
- load_valid in IDLE, FLUSH or DONE: byte dropped, no effect.
- Word address is cnt[13:1]. No wrap is possible because len is clamped to 16384 bytes (8192 words).
- cpu_hold rises the cycle after load_start is accepted and falls on the edge leaving DONE.
- Reset mid-load: FSM returns to IDLE immediately. Words already written are kept; any half-packed lo byte is discarded.
- Throughput: one byte per cycle with load_valid held high. A load of N bytes takes N cycles of acceptance, plus 1 cycle for FLUSH when N is odd, plus 1 cycle for DONE.

Decomposition:
- cpu_common package gains:
  - INST_MEM_WORDS = 8192
  - INST_MEM_BYTES = 16384
  - typedef enum inst_mem_load_state_t {IDLE, LOAD_LO, LOAD_HI, FLUSH, DONE}
- Sub-module inst_mem_ram: simple dual-port, single-clock RAM, 2^ADDR_WIDTH x 16, registered read-first output, synchronous write enable. It must be inferable as block RAM.
- inst_mem holds the loader FSM, counter, latch and hold/done logic.

Test Plan:
- Even load: load_start, load_len=4, bytes 0x11,0x22,0x33,0x44 back-to-back. Required:
  - ram[0]=0x2211, ram[1]=0x4433.
  - load_done pulses exactly once, 1 cycle after the 4th byte is accepted.
  - cpu_hold is high for 5 cycles.
- Odd load with stalls: load_len=3, bytes 0xAA,0xBB,0xCC with a load_valid gap of 2 cycles between each. Required:
  - ram[0]=0xBBAA, ram[1]=0x00CC.
  - Exactly one FLUSH cycle with load_ready=0.
  - Gaps do not consume bytes.
- Read latency: after load, drive mem_inst_addr=0 then 1 on consecutive cycles. Required: mem_instr is 0x2211 then 0x4433, each 1 cycle after its address. Same-address read during a LOAD_HI write returns the old value.
- Boundary lengths:
  - load_len=0: load_done pulses the cycle after load_start, with no writes and no load_ready.
  - load_len=20000: clamped, 16384 bytes are accepted, and the last write lands at word 8191.
- Reset mid-load: rst_async asserted after 3 of 6 bytes. Required:
  - All outputs return to reset values asynchronously.
  - ram[0] keeps its new value, ram[1] is unchanged.
  - A following full load succeeds.
- Protocol misuse:
  - load_start mid-load is ignored; the load completes with the original length.
  - load_valid in IDLE causes no write and no state change.
